// File: rtl/besm_cpu.sv
// -----------------------------------------------------------------------------
// besm_cpu : microprogrammed core of the Micro-BESM processor.
//
// A 4096 x 112 writable microcode store feeds an Am2910-style sequencer through
// a one-stage fetch/execute pipeline: on every edge the sequencer's next
// address (pc_f) is latched as the execute address (control.uPC) and the
// microinstruction at that address is latched into opcode.  A data/tag
// register pair drives the external address/data bus.
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   i_data  in   64-bit read data from memory/bus
//   i_tag   in   8-bit read tag from memory/bus
//   o_ad    out  64-bit address/data output
//   o_tag   out  8-bit tag output
//   o_astb  out  address strobe
//   o_rd    out  read operation
//   o_wr    out  write operation
//
// Trace/backdoor internals: memory, opcode, control.uPC, pc_x, pc_f,
// opcode_x, instruction_retired.
//
// Microinstruction fields (bits numbered [112:1]):
//   sqi[112:109] a[108:97] map[96:95] cce[94] cpol[93] csel[92:90]
//   bop[89:88] ldc[87]; bits [86:1] are not decoded by this core.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// besm_cpu_control : Am2910-style microsequencer.
//
// Ports
//   clk, reset  clock and asynchronous active-high reset
//   sqi_i       4-bit sequencer instruction
//   d_i         12-bit direct/branch operand
//   pass_i      qualified condition
//   upc_o       execute-stage address (uPC)
//   pc_f_o      combinational next fetch address
// -----------------------------------------------------------------------------
module besm_cpu_control (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  sqi_i,
   input  logic [11:0] d_i,
   input  logic        pass_i,
   output logic [11:0] upc_o,
   output logic [11:0] pc_f_o
);

   logic [11:0] uPC;
   logic [11:0] r_q, r_d;
   logic [11:0] stack_q [5];
   logic [2:0]  sp_q;
   logic [11:0] inc, top, pc_f;
   logic [2:0]  wr_idx;
   logic        push_en, pop_en, clr_en, r_nz;

   assign inc    = uPC + 12'd1;
   assign r_nz   = (r_q != 12'd0);
   // An empty stack reads as address 0.
   assign top    = (sp_q == 3'd0) ? 12'd0 : stack_q[sp_q - 3'd1];
   // A push onto a full stack overwrites the top entry instead of growing.
   assign wr_idx = (sp_q == 3'd5) ? 3'd4 : sp_q;

   always_comb begin
      pc_f    = inc;
      r_d     = r_q;
      push_en = 1'b0;
      pop_en  = 1'b0;
      clr_en  = 1'b0;
      case (sqi_i)
         4'd0: begin                                   // JZ
            pc_f   = 12'd0;
            clr_en = 1'b1;
         end
         4'd1: if (pass_i) begin                       // CJS
            push_en = 1'b1;
            pc_f    = d_i;
         end
         4'd2: pc_f = d_i;                             // JMAP
         4'd3, 4'd6: if (pass_i) pc_f = d_i;           // CJP, CJV
         4'd4: begin                                   // PUSH
            push_en = 1'b1;
            if (pass_i) r_d = d_i;
         end
         4'd5: begin                                   // JSRP
            push_en = 1'b1;
            pc_f    = pass_i ? d_i : r_q;
         end
         4'd7: pc_f = pass_i ? d_i : r_q;              // JRP
         4'd8: if (r_nz) begin                         // RFCT
            pc_f = top;
            r_d  = r_q - 12'd1;
         end else begin
            pop_en = 1'b1;
         end
         4'd9: if (r_nz) begin                         // RPCT
            pc_f = d_i;
            r_d  = r_q - 12'd1;
         end
         4'd10: if (pass_i) begin                      // CRTN
            pc_f   = top;
            pop_en = 1'b1;
         end
         4'd11: if (pass_i) begin                      // CJPP
            pc_f   = d_i;
            pop_en = 1'b1;
         end
         4'd12: r_d = d_i;                             // LDCT
         4'd13: if (pass_i) begin                      // LOOP
            pop_en = 1'b1;
         end else begin
            pc_f = top;
         end
         4'd14: begin                                  // CONT
         end
         default: begin                                // TWB
            if (pass_i) begin
               pop_en = 1'b1;
            end else if (r_nz) begin
               pc_f = top;
               r_d  = r_q - 12'd1;
            end else begin
               pc_f   = d_i;
               pop_en = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uPC  <= 12'd0;
         r_q  <= 12'd0;
         sp_q <= 3'd0;
      end else begin
         uPC <= pc_f;
         r_q <= r_d;
         if (clr_en) begin
            sp_q <= 3'd0;
         end else if (push_en) begin
            if (sp_q != 3'd5) sp_q <= sp_q + 3'd1;
         end else if (pop_en && sp_q != 3'd0) begin
            sp_q <= sp_q - 3'd1;
         end
      end
   end

   // Stack contents are plain storage; only the pointer needs a reset.
   always_ff @(posedge clk) begin
      if (push_en && !reset) stack_q[wr_idx] <= inc;
   end

   assign upc_o  = uPC;
   assign pc_f_o = pc_f;

endmodule

module besm_cpu (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] i_data,
   input  logic [7:0]  i_tag,
   output logic [63:0] o_ad,
   output logic [7:0]  o_tag,
   output logic        o_astb,
   output logic        o_rd,
   output logic        o_wr
);

   logic [112:1] memory [0:4095];
   logic [112:1] opcode;
   logic [63:0]  data_reg;
   logic [7:0]   tag_reg;

   logic [11:0]  pc_x, pc_f;
   logic [112:1] opcode_x;
   logic         instruction_retired;

   logic [3:0]   sqi_f;
   logic [11:0]  a_f;
   logic [1:0]   map_f, bop_f;
   logic [2:0]   csel_f;
   logic         cce_f, cpol_f, ldc_f;
   logic [11:0]  d_val;
   logic         cond, pass;
   logic         unused_opcode_bits;

   assign sqi_f  = opcode[112:109];
   assign a_f    = opcode[108:97];
   assign map_f  = opcode[96:95];
   assign cce_f  = opcode[94];
   assign cpol_f = opcode[93];
   assign csel_f = opcode[92:90];
   assign bop_f  = opcode[89:88];
   assign ldc_f  = opcode[87];
   assign unused_opcode_bits = ^opcode[86:1];

   always_comb begin
      d_val = 12'd0;
      case (map_f)
         2'd0:    d_val = a_f;
         2'd1:    d_val = data_reg[11:0];
         2'd2:    d_val = {4'b0, tag_reg};
         default: d_val = 12'd0;
      endcase
   end

   always_comb begin
      cond = 1'b0;
      case (csel_f)
         3'd0:    cond = 1'b1;
         3'd1:    cond = (data_reg == 64'd0);
         3'd2:    cond = data_reg[63];
         3'd3:    cond = tag_reg[0];
         default: cond = 1'b0;
      endcase
   end

   assign pass = !cce_f | (cond ^ cpol_f);

   besm_cpu_control control (
      .clk    (clk),
      .reset  (reset),
      .sqi_i  (sqi_f),
      .d_i    (d_val),
      .pass_i (pass),
      .upc_o  (pc_x),
      .pc_f_o (pc_f)
   );

   // Fetch/execute boundary: the word at pc_f becomes the executing opcode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opcode              <= '0;
         instruction_retired <= 1'b0;
      end else begin
         opcode              <= memory[pc_f];
         instruction_retired <= ~instruction_retired;
      end
   end

   // A bus read takes priority over the ldc constant load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg <= 64'd0;
         tag_reg  <= 8'd0;
      end else if (bop_f == 2'd1) begin
         data_reg <= i_data;
         tag_reg  <= i_tag;
      end else if (ldc_f) begin
         data_reg <= {52'b0, a_f};
      end
   end

   assign opcode_x = opcode;

   always_comb begin
      o_rd   = (bop_f == 2'd1);
      o_wr   = (bop_f == 2'd2);
      o_astb = (bop_f == 2'd3);
      o_ad   = 64'd0;
      o_tag  = 8'd0;
      if (bop_f == 2'd3) begin
         o_ad = {52'b0, a_f};
      end else if (bop_f == 2'd2) begin
         o_ad  = data_reg;
         o_tag = tag_reg;
      end
   end

endmodule

// File: tb/tb_besm_cpu.sv
// -----------------------------------------------------------------------------
// tb_besm_cpu : self-checking bench for besm_cpu.
// Loads microprograms through the memory backdoor, runs directed programs and
// a random program, and compares the core against an instruction-level model
// that interprets the microcode words directly.
// -----------------------------------------------------------------------------
module tb_besm_cpu;

   logic        clk;
   logic        reset;
   logic [63:0] i_data;
   logic [7:0]  i_tag;
   logic [63:0] o_ad;
   logic [7:0]  o_tag;
   logic        o_astb, o_rd, o_wr;

   besm_cpu dut (
      .clk    (clk),
      .reset  (reset),
      .i_data (i_data),
      .i_tag  (i_tag),
      .o_ad   (o_ad),
      .o_tag  (o_tag),
      .o_astb (o_astb),
      .o_rd   (o_rd),
      .o_wr   (o_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit rand_bus = 1'b0;

   logic [112:1] img [0:4095];

   // Reference model state
   int           m_upc;
   logic [112:1] m_op;
   int           m_R;
   int           stk[$];
   logic [63:0]  m_data;
   logic [7:0]   m_tag;
   logic         m_ret;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [112:1] enc(int sqi, int a, int map = 0, int cce = 0,
                                        int cpol = 0, int csel = 0, int bop = 0, int ldc = 0);
      logic [112:1] w;
      w = '0;
      w[112:109] = sqi[3:0];
      w[108:97]  = a[11:0];
      w[96:95]   = map[1:0];
      w[94]      = cce[0];
      w[93]      = cpol[0];
      w[92:90]   = csel[2:0];
      w[89:88]   = bop[1:0];
      w[87]      = ldc[0];
      return w;
   endfunction

   task automatic model_reset();
      m_upc  = 0;
      m_op   = '0;
      m_R    = 0;
      stk.delete();
      m_data = '0;
      m_tag  = '0;
      m_ret  = 1'b0;
   endtask

   // Interprets the executing word; with apply=1 it also retires it.
   task automatic model_eval(input bit apply, output int nxt);
      int sqi, a, map, bop, csel, inc, d, top, rn, op;
      bit cce, cpol, ldc, cond, pass;
      sqi  = int'(m_op[112:109]);
      a    = int'(m_op[108:97]);
      map  = int'(m_op[96:95]);
      cce  = m_op[94];
      cpol = m_op[93];
      csel = int'(m_op[92:90]);
      bop  = int'(m_op[89:88]);
      ldc  = m_op[87];
      case (map)
         0: d = a;
         1: d = int'(m_data[11:0]);
         2: d = int'(m_tag);
         default: d = 0;
      endcase
      case (csel)
         0: cond = 1;
         1: cond = (m_data == 64'd0);
         2: cond = m_data[63];
         3: cond = m_tag[0];
         default: cond = 0;
      endcase
      pass = !cce || (cond != cpol);
      inc  = (m_upc + 1) % 4096;
      top  = (stk.size() > 0) ? stk[stk.size()-1] : 0;
      rn   = m_R;
      op   = 0;      // 0 none, 1 push, 2 pop, 3 clear
      nxt  = inc;
      case (sqi)
         0: begin nxt = 0; op = 3; end
         1: if (pass) begin op = 1; nxt = d; end
         2: nxt = d;
         3, 6: if (pass) nxt = d;
         4: begin op = 1; if (pass) rn = d; end
         5: begin op = 1; nxt = pass ? d : m_R; end
         7: nxt = pass ? d : m_R;
         8: if (m_R != 0) begin nxt = top; rn = m_R - 1; end else op = 2;
         9: if (m_R != 0) begin nxt = d; rn = m_R - 1; end
         10: if (pass) begin nxt = top; op = 2; end
         11: if (pass) begin nxt = d; op = 2; end
         12: rn = d;
         13: if (pass) op = 2; else nxt = top;
         14: ;
         default: begin
            if (pass) op = 2;
            else if (m_R != 0) begin nxt = top; rn = m_R - 1; end
            else begin nxt = d; op = 2; end
         end
      endcase
      if (apply) begin
         case (op)
            1: if (stk.size() < 5) stk.push_back(inc); else stk[4] = inc;
            2: if (stk.size() > 0) void'(stk.pop_back());
            3: stk.delete();
            default: ;
         endcase
         m_R = rn;
         if (bop == 1) begin
            m_data = i_data;
            m_tag  = i_tag;
         end else if (ldc) begin
            m_data = {52'b0, m_op[108:97]};
         end
         m_upc = nxt;
         m_op  = img[nxt];
         m_ret = ~m_ret;
      end
   endtask

   task automatic check_all();
      int nf, bop;
      logic [63:0] e_ad;
      logic [7:0]  e_tag;
      model_eval(1'b0, nf);
      bop   = int'(m_op[89:88]);
      e_ad  = (bop == 3) ? {52'b0, m_op[108:97]} : (bop == 2) ? m_data : 64'd0;
      e_tag = (bop == 2) ? m_tag : 8'd0;
      chk("pc_x",     dut.pc_x, m_upc);
      chk("pc_f",     dut.pc_f, nf);
      chk("opcode_x", dut.opcode_x, m_op);
      chk("retired",  dut.instruction_retired, m_ret);
      chk("o_rd",     o_rd,   bop == 1);
      chk("o_wr",     o_wr,   bop == 2);
      chk("o_astb",   o_astb, bop == 3);
      chk("o_ad",     o_ad,   e_ad);
      chk("o_tag",    o_tag,  e_tag);
   endtask

   task automatic step();
      int nf;
      @(posedge clk);
      model_eval(1'b1, nf);
      #1;
      check_all();
      if (rand_bus) begin
         i_data = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
         i_tag  = 8'($urandom);
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic fill_cont();
      for (int k = 0; k < 4096; k++) img[k] = enc(14, 0);
   endtask

   task automatic load_and_reset();
      dut.memory = img;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int seq [5];
      reset  = 1'b1;
      i_data = '0;
      i_tag  = '0;
      model_reset();

      // Sequential flow and 4095 -> 0 wrap
      fill_cont();
      load_and_reset();
      chk("rst_pc_f", dut.pc_f, 0);
      chk("rst_o_ad", o_ad, 0);
      step();
      chk("first_pc", dut.pc_x, 0);
      run(4095);
      chk("wrap_4095", dut.pc_x, 4095);
      step();
      chk("wrap_0", dut.pc_x, 0);

      // Conditional jump taken / not taken
      fill_cont();
      img[5] = enc(3, 100, 0, 1, 0, 0);
      load_and_reset();
      run(6);
      chk("cjp_at5", dut.pc_x, 5);
      step();
      chk("cjp_taken", dut.pc_x, 100);
      img[5] = enc(3, 100, 0, 1, 1, 0);
      load_and_reset();
      run(7);
      chk("cjp_not_taken", dut.pc_x, 6);

      // Subroutine call and return
      fill_cont();
      img[10]  = enc(1, 200);
      img[200] = enc(10, 0);
      load_and_reset();
      run(12);
      chk("cjs_target", dut.pc_x, 200);
      step();
      chk("crtn_return", dut.pc_x, 11);

      // Six nested calls: the sixth push overwrites the fifth return address
      fill_cont();
      img[30] = enc(1, 40);
      img[40] = enc(1, 50);
      img[50] = enc(1, 60);
      img[60] = enc(1, 70);
      img[70] = enc(1, 80);
      img[80] = enc(1, 90);
      img[90] = enc(10, 0);
      img[81] = enc(10, 0);
      img[61] = enc(10, 0);
      img[51] = enc(10, 0);
      img[41] = enc(10, 0);
      img[31] = enc(10, 0);
      load_and_reset();
      run(37);
      chk("nest_deep", dut.pc_x, 90);
      run(2);
      chk("nest_overwrite", dut.pc_x, 61);
      run(4);
      chk("nest_empty_ret", dut.pc_x, 0);
      run(40);

      // Counter loop
      fill_cont();
      img[20] = enc(12, 3);
      img[21] = enc(9, 21);
      load_and_reset();
      run(21);
      chk("loop_start", dut.pc_x, 20);
      seq = '{21, 21, 21, 21, 22};
      for (int k = 0; k < 5; k++) begin
         step();
         chk("loop_seq", dut.pc_x, seq[k]);
      end

      // Bus strobe, read, write
      fill_cont();
      img[1] = enc(14, 'h123, 0, 0, 0, 0, 3);
      img[2] = enc(14, 0, 0, 0, 0, 0, 1);
      img[3] = enc(14, 0, 0, 0, 0, 0, 2);
      i_data = 64'h55;
      i_tag  = 8'h7;
      load_and_reset();
      run(2);
      chk("astb", o_astb, 1);
      chk("astb_ad", o_ad, 'h123);
      step();
      chk("rd", o_rd, 1);
      step();
      chk("wr", o_wr, 1);
      chk("wr_ad", o_ad, 'h55);
      chk("wr_tag", o_tag, 'h7);

      // Reset mid-run
      fill_cont();
      load_and_reset();
      run(301);
      chk("pre_reset_pc", dut.pc_x, 300);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_pc", dut.pc_x, 0);
      chk("mid_rst_ad", o_ad, 0);
      chk("mid_rst_tag", o_tag, 0);
      chk("mid_rst_strb", {o_astb, o_rd, o_wr}, 0);
      @(negedge clk);
      reset = 1'b0;
      step();
      chk("post_rst_pc", dut.pc_x, 0);
      step();
      chk("post_rst_pc1", dut.pc_x, 1);

      // Random microprogram against the model
      for (int k = 0; k < 4096; k++)
         img[k] = enc($urandom_range(0, 15), $urandom_range(0, 4095), $urandom_range(0, 3),
                      $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                      $urandom_range(0, 3), $urandom_range(0, 1));
      rand_bus = 1'b1;
      load_and_reset();
      run(3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/besm_cpu.md
# besm_cpu

Microprogrammed core of the Micro-BESM processor. It holds a writable 4096×112 microinstruction store and an Am2910-style microsequencer with a one-stage fetch/execute pipeline. A minimal data/tag register pair drives the external address/data bus. It exports trace signals that the tracer monitor and the microcode test benches use to observe execution.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_data  in  64  read data from memory/bus.
- i_tag  in  8  read tag from memory/bus.
- o_ad  out  64  address/data output.
- o_tag  out  8  tag output.
- o_astb  out  1  address strobe.
- o_rd  out  1  read operation.
- o_wr  out  1  write operation.
- Hierarchically accessible internals, required for loading and tracing:
  - memory[4096] of 112 bits: the microcode store, loadable by whole-array assignment.
  - control.uPC (12): execute-stage address.
  - opcode (112): microinstruction being executed.
  - Trace outputs pc_x (= uPC), pc_f (next fetch address, 12), opcode_x (= opcode) and instruction_retired (1 bit, toggles once per retired microinstruction).

## Operation
- Microinstruction bits are numbered [112:1].
- Fields:
  - sqi [112:109]: sequencer instruction.
  - a [108:97]: 12-bit address/constant.
  - map [96:95]: D source. 0 PE = a; 1 ME = data_reg[11:0]; 2 VE = {4'b0, tag_reg}; 3 gives D = 0.
  - cce [94]: condition enable.
  - cpol [93]: invert condition.
  - csel [92:90]: condition source. 0 gives 1; 1 gives data_reg==0; 2 gives data_reg[63]; 3 gives tag_reg[0]; 4–7 give 0.
  - bop [89:88]: bus op. 0 none, 1 read, 2 write, 3 strobe.
  - ldc [87]: load data_reg from a, zero-extended.
- pass = !cce | (cond ^ cpol). inc = uPC+1, mod 4096 (4095 wraps to 0).
- State:
  - Counter R (12 bits).
  - Stack of 5 × 12 bits with pointer sp (0..5).
  - A push when full overwrites the top entry. A pop when empty is ignored. top = stack[sp-1], or 0 when empty.
- Sequencer (pc_f is combinational):
  - 0 JZ: pc_f=0, clear stack.
  - 1 CJS: if pass, push inc and pc_f=D; else pc_f=inc.
  - 2 JMAP: pc_f=D.
  - 3 CJP and 6 CJV: pc_f = pass ? D : inc.
  - 4 PUSH: push inc; if pass, R<=D; pc_f=inc.
  - 5 JSRP: push inc; pc_f = pass ? D : R.
  - 7 JRP: pc_f = pass ? D : R.
  - 8 RFCT: if R≠0, pc_f=top and R--; else pop and pc_f=inc.
  - 9 RPCT: if R≠0, pc_f=D and R--; else pc_f=inc.
  - 10 CRTN: if pass, pc_f=top and pop; else pc_f=inc.
  - 11 CJPP: if pass, pc_f=D and pop; else pc_f=inc.
  - 12 LDCT: R<=D, pc_f=inc.
  - 13 LOOP: if pass, pop and pc_f=inc; else pc_f=top.
  - 14 CONT: pc_f=inc.
  - 15 TWB:
    - pass: pop, pc_f=inc.
    - fail with R≠0: pc_f=top, R--.
    - fail with R=0: pc_f=D, pop.
- Pipeline: on each edge, uPC<=pc_f and opcode<=memory[pc_f].
- Bus outputs (combinational from opcode):
  - o_rd = bop==1; o_wr = bop==2; o_astb = bop==3.
  - o_ad = {52'b0, a} when bop==3; data_reg when bop==2; else 0.
  - o_tag = tag_reg when bop==2; else 0.
- Register loads on the edge:
  - bop==1: data_reg<=i_data, tag_reg<=i_tag.
  - ldc: data_reg<={52'b0,a}. If both apply, the read wins.
- Backdoor writes to uPC or opcode between edges take effect immediately: pc_f recomputes from the new values.

## Timing
- Reset (asynchronous) sets:
  - uPC=0, opcode=0, R=0, sp=0, data_reg=0, tag_reg=0.
  - All outputs are 0.
  - pc_f=0, because opcode 0 is JZ.
- First edge after reset release: loads memory[0], so pc_x=0.
- One microinstruction retires per cycle; there are no stalls.
- Branch effect: the instruction at pc_f executes on the next cycle; there are no delay slots.
- instruction_retired toggles on every rising edge while reset is low.
- Reset asserted mid-run aborts immediately. Memory contents are preserved.

## Test plan
- Sequential flow: reset, then store all CONT. Required: pc_x follows 0,1,2,…; after 4096 cycles it wraps 4095→0. instruction_retired toggles every cycle.
- Conditional jump:
  - At 5: CJP, a=100, cce=1, csel=0. Required: pc_x 5→100.
  - Same with cpol=1. Required: pc_x 5→6.
- Subroutine:
  - At 10: CJS, a=200. At 200: CRTN, cce=0. Required: pc_x 10→200→11.
  - Six nested CJS. Required: the fifth push is overwritten; no hang.
- Counter loop: LDCT a=3 at 20, then RPCT a=21 at 21. Required: pc_x sequence 20,21,21,21,21,22 (R: 3→2→1→0).
- Bus:
  - bop=3, a=0x123. Required: o_astb=1, o_ad=0x123.
  - bop=1 with i_data=0x55, i_tag=0x7. Required: data_reg=0x55, tag_reg=0x7.
  - Next bop=2. Required: o_wr=1, o_ad=0x55, o_tag=0x7.
- Reset mid-run: assert reset while pc_x=300. Required: all outputs 0 immediately; pc_x=0 after release.
